trap_ctrl: RTL and testbench



---
 rtl/trap_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_trap_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer at the writeback boundary.
// On an exception, interrupt or mret seen in wb it flushes the pipeline,
// walks the CSR updates through the single CSR write port, then issues a
// one-cycle fetch redirect.
// Optional feature macro: TRAP_MTVAL_EN adds the MTVAL write step and the
// mtval capture register.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | watching wb for exception / interrupt / mret
// S_MEPC    | writing saved PC to mepc (0x341)
// S_MCAUSE  | writing saved cause to mcause (0x342)
// S_MTVAL   | writing saved trap value to mtval (0x343), macro builds only
// S_MSTATUS | writing updated mstatus (0x300)
// S_JUMP    | redirecting fetch to the handler or to mepc
module trap_ctrl #(
  parameter int XLEN       = 32,
  parameter int CSR_ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_valid,
  input  logic [XLEN-1:0]       wb_pc,
  input  logic [XLEN-1:0]       wb_inst,
  input  logic                  wb_exp_flag,
  input  logic                  wb_inst_addr_misal,
  input  logic                  wb_is_illg_inst,
  input  logic                  wb_is_ebreak_inst,
  input  logic                  wb_is_ecall_inst,
  input  logic                  wb_is_mret_inst,
  input  logic                  int_req,
  input  logic [XLEN-1:0]       mstatus_in,
  input  logic [XLEN-1:0]       mtvec_in,
  input  logic [XLEN-1:0]       mepc_in,
  output logic                  int_flag,
  output logic                  pipe_flush,
  output logic                  csr_we,
  output logic [CSR_ADDR_W-1:0] csr_waddr,
  output logic [XLEN-1:0]       csr_wdata,
  output logic                  redirect_valid,
  output logic [XLEN-1:0]       redirect_pc,
  output logic                  trap_busy
);

  localparam logic [CSR_ADDR_W-1:0] ADDR_MSTATUS = CSR_ADDR_W'(12'h300);
  localparam logic [CSR_ADDR_W-1:0] ADDR_MEPC    = CSR_ADDR_W'(12'h341);
  localparam logic [CSR_ADDR_W-1:0] ADDR_MCAUSE  = CSR_ADDR_W'(12'h342);
`ifdef TRAP_MTVAL_EN
  localparam logic [CSR_ADDR_W-1:0] ADDR_MTVAL   = CSR_ADDR_W'(12'h343);
`endif

  localparam logic [XLEN-1:0] CAUSE_MISAL  = XLEN'(0);
  localparam logic [XLEN-1:0] CAUSE_ILLG   = XLEN'(2);
  localparam logic [XLEN-1:0] CAUSE_EBREAK = XLEN'(3);
  localparam logic [XLEN-1:0] CAUSE_ECALL  = XLEN'(11);
  localparam logic [XLEN-1:0] CAUSE_M_EXT  = {1'b1, (XLEN-1)'(11)};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MEPC    = 3'd1,
    S_MCAUSE  = 3'd2,
`ifdef TRAP_MTVAL_EN
    S_MTVAL   = 3'd3,
`endif
    S_MSTATUS = 3'd4,
    S_JUMP    = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic            is_mret_q, is_mret_d;
  logic [XLEN-1:0] redirect_pc_q;
`ifdef TRAP_MTVAL_EN
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [XLEN-1:0] mtval_sel;
`else
  logic            unused_inst;
  assign unused_inst = ^wb_inst;
`endif

  logic            in_idle;
  logic            exp_take, int_take, mret_take, any_take;
  logic [XLEN-1:0] exp_cause;
  logic [XLEN-1:0] mstatus_trap, mstatus_mret;

  // Take decode; reset gates it so every output is quiet while rst is high.
  always_comb begin
    in_idle   = (state_q == S_IDLE) & ~rst;
    exp_take  = in_idle & wb_valid & wb_exp_flag;
    int_take  = in_idle & wb_valid & ~wb_exp_flag & int_req & mstatus_in[3];
    mret_take = in_idle & wb_valid & ~wb_exp_flag & ~int_take & wb_is_mret_inst;
    any_take  = exp_take | int_take | mret_take;
  end

  // Exception cause priority; a flagged exception with no cause bit reports illegal.
  always_comb begin
    exp_cause = CAUSE_ILLG;
    if (wb_inst_addr_misal)     exp_cause = CAUSE_MISAL;
    else if (wb_is_illg_inst)   exp_cause = CAUSE_ILLG;
    else if (wb_is_ebreak_inst) exp_cause = CAUSE_EBREAK;
    else if (wb_is_ecall_inst)  exp_cause = CAUSE_ECALL;
  end

`ifdef TRAP_MTVAL_EN
  // Trap value: faulting PC for misaligned, instruction word for illegal.
  always_comb begin
    mtval_sel = '0;
    if (exp_take) begin
      if (wb_inst_addr_misal)   mtval_sel = wb_pc;
      else if (wb_is_illg_inst) mtval_sel = wb_inst;
    end
  end
`endif

  // mstatus images for trap entry and mret; MPP is always forced to machine.
  always_comb begin
    mstatus_trap        = mstatus_in;
    mstatus_trap[7]     = mstatus_in[3];
    mstatus_trap[3]     = 1'b0;
    mstatus_trap[12:11] = 2'b11;
    mstatus_mret        = mstatus_in;
    mstatus_mret[3]     = mstatus_in[7];
    mstatus_mret[7]     = 1'b1;
    mstatus_mret[12:11] = 2'b11;
  end

  // Next state, capture values and all sequencer outputs.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    cause_d        = cause_q;
    is_mret_d      = is_mret_q;
`ifdef TRAP_MTVAL_EN
    mtval_d        = mtval_q;
`endif
    int_flag       = 1'b0;
    pipe_flush     = 1'b0;
    csr_we         = 1'b0;
    csr_waddr      = '0;
    csr_wdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = redirect_pc_q;
    trap_busy      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        int_flag   = int_take;
        pipe_flush = any_take;
        if (any_take) begin
          pc_d      = wb_pc;
          cause_d   = exp_take ? exp_cause : (int_take ? CAUSE_M_EXT : '0);
          is_mret_d = mret_take;
`ifdef TRAP_MTVAL_EN
          mtval_d   = mtval_sel;
`endif
          state_d   = mret_take ? S_MSTATUS : S_MEPC;
        end
      end
      S_MEPC: begin
        pipe_flush = 1'b1;
        trap_busy  = 1'b1;
        csr_we     = 1'b1;
        csr_waddr  = ADDR_MEPC;
        csr_wdata  = pc_q;
        state_d    = S_MCAUSE;
      end
      S_MCAUSE: begin
        pipe_flush = 1'b1;
        trap_busy  = 1'b1;
        csr_we     = 1'b1;
        csr_waddr  = ADDR_MCAUSE;
        csr_wdata  = cause_q;
`ifdef TRAP_MTVAL_EN
        state_d    = S_MTVAL;
`else
        state_d    = S_MSTATUS;
`endif
      end
`ifdef TRAP_MTVAL_EN
      S_MTVAL: begin
        pipe_flush = 1'b1;
        trap_busy  = 1'b1;
        csr_we     = 1'b1;
        csr_waddr  = ADDR_MTVAL;
        csr_wdata  = mtval_q;
        state_d    = S_MSTATUS;
      end
`endif
      S_MSTATUS: begin
        pipe_flush = 1'b1;
        trap_busy  = 1'b1;
        csr_we     = 1'b1;
        csr_waddr  = ADDR_MSTATUS;
        csr_wdata  = is_mret_q ? mstatus_mret : mstatus_trap;
        state_d    = S_JUMP;
      end
      S_JUMP: begin
        pipe_flush     = 1'b1;
        trap_busy      = 1'b1;
        redirect_valid = 1'b1;
        // Direct mode only: the mode bits of mtvec are dropped.
        redirect_pc    = is_mret_q ? mepc_in : {mtvec_in[XLEN-1:2], 2'b00};
        state_d        = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, capture and redirect-target registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      cause_q       <= '0;
      is_mret_q     <= 1'b0;
      redirect_pc_q <= '0;
`ifdef TRAP_MTVAL_EN
      mtval_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      cause_q       <= cause_d;
      is_mret_q     <= is_mret_d;
      redirect_pc_q <= redirect_pc;
`ifdef TRAP_MTVAL_EN
      mtval_q       <= mtval_d;
`endif
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl; expected values are hand-computed constants.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [31:0] wb_inst;
  logic        wb_exp_flag;
  logic        wb_inst_addr_misal;
  logic        wb_is_illg_inst;
  logic        wb_is_ebreak_inst;
  logic        wb_is_ecall_inst;
  logic        wb_is_mret_inst;
  logic        int_req;
  logic [31:0] mstatus_in;
  logic [31:0] mtvec_in;
  logic [31:0] mepc_in;
  logic        int_flag;
  logic        pipe_flush;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_busy;

  int n_tests = 0;
  int n_fail  = 0;

  trap_ctrl #(.XLEN(32), .CSR_ADDR_W(12)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_inst(wb_inst),
    .wb_exp_flag(wb_exp_flag), .wb_inst_addr_misal(wb_inst_addr_misal),
    .wb_is_illg_inst(wb_is_illg_inst), .wb_is_ebreak_inst(wb_is_ebreak_inst),
    .wb_is_ecall_inst(wb_is_ecall_inst), .wb_is_mret_inst(wb_is_mret_inst),
    .int_req(int_req), .mstatus_in(mstatus_in), .mtvec_in(mtvec_in),
    .mepc_in(mepc_in), .int_flag(int_flag), .pipe_flush(pipe_flush),
    .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_busy(trap_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_wb();
    wb_valid = 0; wb_exp_flag = 0; wb_inst_addr_misal = 0;
    wb_is_illg_inst = 0; wb_is_ebreak_inst = 0; wb_is_ecall_inst = 0;
    wb_is_mret_inst = 0; int_req = 0;
  endtask

  task automatic chk_csr(input string tag, input logic [11:0] a, input logic [31:0] d);
    chk({tag, "_we"},    {31'b0, csr_we}, 32'd1);
    chk({tag, "_addr"},  {20'b0, csr_waddr}, {20'b0, a});
    chk({tag, "_data"},  csr_wdata, d);
    chk({tag, "_flush"}, {31'b0, pipe_flush}, 32'd1);
    chk({tag, "_busy"},  {31'b0, trap_busy}, 32'd1);
  endtask

  task automatic chk_jump(input string tag, input logic [31:0] pc);
    chk({tag, "_rv"},    {31'b0, redirect_valid}, 32'd1);
    chk({tag, "_rpc"},   redirect_pc, pc);
    chk({tag, "_we"},    {31'b0, csr_we}, 32'd0);
    chk({tag, "_addr"},  {20'b0, csr_waddr}, 32'd0);
    chk({tag, "_flush"}, {31'b0, pipe_flush}, 32'd1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},  {31'b0, trap_busy}, 32'd0);
    chk({tag, "_flush"}, {31'b0, pipe_flush}, 32'd0);
    chk({tag, "_rv"},    {31'b0, redirect_valid}, 32'd0);
    chk({tag, "_we"},    {31'b0, csr_we}, 32'd0);
  endtask

  initial begin
    rst = 1;
    clear_wb();
    wb_pc = 0; wb_inst = 0; mstatus_in = 0; mtvec_in = 0; mepc_in = 0;
    #3;
    chk("rst_busy",  {31'b0, trap_busy}, 32'd0);
    chk("rst_flush", {31'b0, pipe_flush}, 32'd0);
    chk("rst_we",    {31'b0, csr_we}, 32'd0);
    chk("rst_addr",  {20'b0, csr_waddr}, 32'd0);
    chk("rst_rpc",   redirect_pc, 32'd0);
    tick(); tick();
    rst = 0;
    tick();

    // Illegal instruction trap
    wb_valid = 1; wb_exp_flag = 1; wb_is_illg_inst = 1;
    wb_pc = 32'h100; wb_inst = 32'hFFFF_FFFF; mtvec_in = 32'h201; mstatus_in = 32'h8;
    #1;
    chk("ill_T_flush", {31'b0, pipe_flush}, 32'd1);
    chk("ill_T_int",   {31'b0, int_flag}, 32'd0);
    chk("ill_T_busy",  {31'b0, trap_busy}, 32'd0);
    tick(); clear_wb(); #1;
    chk_csr("ill_mepc", 12'h341, 32'h100);
    tick();
    chk_csr("ill_mcause", 12'h342, 32'd2);
`ifdef TRAP_MTVAL_EN
    tick();
    chk_csr("ill_mtval", 12'h343, 32'hFFFF_FFFF);
`endif
    tick();
    chk_csr("ill_mstatus", 12'h300, 32'h1880);
    tick();
    chk_jump("ill_jump", 32'h200);
    tick();
    chk_idle("ill_done");
    chk("ill_rpc_hold", redirect_pc, 32'h200);

    // Interrupt; take inputs stay asserted while busy and must be ignored
    wb_valid = 1; int_req = 1; mstatus_in = 32'h8; wb_pc = 32'h80;
    #1;
    chk("irq_T_int",   {31'b0, int_flag}, 32'd1);
    chk("irq_T_flush", {31'b0, pipe_flush}, 32'd1);
    tick();
    chk("irq_T1_int", {31'b0, int_flag}, 32'd0);
    chk_csr("irq_mepc", 12'h341, 32'h80);
    tick();
    chk("irq_T2_int", {31'b0, int_flag}, 32'd0);
    chk_csr("irq_mcause", 12'h342, 32'h8000_000B);
`ifdef TRAP_MTVAL_EN
    tick();
    chk_csr("irq_mtval", 12'h343, 32'h0);
`endif
    tick();
    chk_csr("irq_mstatus", 12'h300, 32'h1880);
    tick();
    chk_jump("irq_jump", 32'h200);
    clear_wb();
    tick();
    chk_idle("irq_done");

    // Simultaneous ecall exception and interrupt
    wb_valid = 1; wb_exp_flag = 1; wb_is_ecall_inst = 1; int_req = 1;
    mstatus_in = 32'h8; wb_pc = 32'h300;
    #1;
    chk("sim_T_int",   {31'b0, int_flag}, 32'd0);
    chk("sim_T_flush", {31'b0, pipe_flush}, 32'd1);
    tick(); clear_wb(); #1;
    chk_csr("sim_mepc", 12'h341, 32'h300);
    tick();
    chk_csr("sim_mcause", 12'h342, 32'd11);
`ifdef TRAP_MTVAL_EN
    tick();
    chk_csr("sim_mtval", 12'h343, 32'h0);
`endif
    tick();
    chk_csr("sim_mstatus", 12'h300, 32'h1880);
    tick();
    chk_jump("sim_jump", 32'h200);
    tick();
    chk_idle("sim_done");

    // Mret
    wb_valid = 1; wb_is_mret_inst = 1; mstatus_in = 32'h80; mepc_in = 32'h400;
    #1;
    chk("mret_T_flush", {31'b0, pipe_flush}, 32'd1);
    chk("mret_T_int",   {31'b0, int_flag}, 32'd0);
    tick(); clear_wb(); #1;
    chk_csr("mret_mstatus", 12'h300, 32'h1888);
    tick();
    chk_jump("mret_jump", 32'h400);
    tick();
    chk_idle("mret_done");

    // Blocked interrupt: MIE clear, then wb not valid
    wb_valid = 1; int_req = 1; mstatus_in = 32'h0; wb_pc = 32'h600;
    #1;
    chk("blk_mie_int",   {31'b0, int_flag}, 32'd0);
    chk("blk_mie_flush", {31'b0, pipe_flush}, 32'd0);
    tick();
    chk_idle("blk_mie_after");
    wb_valid = 0; mstatus_in = 32'h8;
    #1;
    chk("blk_nv_int",   {31'b0, int_flag}, 32'd0);
    chk("blk_nv_flush", {31'b0, pipe_flush}, 32'd0);
    tick();
    chk_idle("blk_nv_after");
    clear_wb();

    // Reset in MCAUSE, then a new take
    wb_valid = 1; wb_exp_flag = 1; wb_inst_addr_misal = 1; wb_pc = 32'h104;
    #1;
    chk("rmid_T_flush", {31'b0, pipe_flush}, 32'd1);
    tick(); clear_wb(); #1;
    chk_csr("rmid_mepc", 12'h341, 32'h104);
    tick();
    chk_csr("rmid_mcause", 12'h342, 32'd0);
    rst = 1;
    #1;
    chk("rmid_we",    {31'b0, csr_we}, 32'd0);
    chk("rmid_addr",  {20'b0, csr_waddr}, 32'd0);
    chk("rmid_data",  csr_wdata, 32'd0);
    chk("rmid_busy",  {31'b0, trap_busy}, 32'd0);
    chk("rmid_flush", {31'b0, pipe_flush}, 32'd0);
    chk("rmid_rpc",   redirect_pc, 32'd0);
    tick();
    rst = 0;
    tick();
    chk_idle("rmid_idle");
    wb_valid = 1; wb_exp_flag = 1; wb_is_ebreak_inst = 1; wb_pc = 32'h500;
    #1;
    chk("post_T_flush", {31'b0, pipe_flush}, 32'd1);
    tick(); clear_wb(); #1;
    chk_csr("post_mepc", 12'h341, 32'h500);
    tick();
    chk_csr("post_mcause", 12'h342, 32'd3);
`ifdef TRAP_MTVAL_EN
    tick();
    chk_csr("post_mtval", 12'h343, 32'h0);
`endif
    tick();
    chk_csr("post_mstatus", 12'h300, 32'h1880);
    tick();
    chk_jump("post_jump", 32'h200);
    tick();
    chk_idle("post_done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
